// File: rtl/axi_axis_reader.sv
// AXI4-Lite read slave that drains an AXI4-Stream input through a circular FIFO.
// Optional macro AXI_AXIS_READER_EMPTY_ERR_EN: data reads while empty return SLVERR.
module axi_axis_reader #(
    parameter int unsigned AXI_DATA_WIDTH  = 32,
    parameter int unsigned AXI_ADDR_WIDTH  = 16,
    parameter int unsigned FIFO_ADDR_WIDTH = 3
) (
    input  logic                      aclk,
    input  logic                      aresetn,

    input  logic [AXI_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,

    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,

    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0] s_axi_wdata,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready
);

    localparam int unsigned DEPTH = 1 << FIFO_ADDR_WIDTH;
    localparam int unsigned CW    = FIFO_ADDR_WIDTH + 1;

    localparam logic [CW-1:0]              CNT_FULL = {1'b1, {FIFO_ADDR_WIDTH{1'b0}}};
    localparam logic [CW-1:0]              CNT_ONE  = {{FIFO_ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [FIFO_ADDR_WIDTH-1:0] PTR_ONE  = {{(FIFO_ADDR_WIDTH-1){1'b0}}, 1'b1};

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RESP = 1'b1;

    logic [AXI_DATA_WIDTH-1:0]  mem_q [DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]              count_q, count_d;
    logic [0:0]                 state_q, state_d;
    logic [AXI_DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic [1:0]                 rresp_q, rresp_d;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic ar_hs;
    logic is_status;

    assign full      = (count_q == CNT_FULL);
    assign empty     = (count_q == '0);
    assign push      = s_axis_tvalid & ~full;
    assign ar_hs     = (state_q == ST_IDLE) & s_axi_arvalid;
    assign is_status = s_axi_araddr[2];
    // Empty is judged on the pre-edge count, so a same-cycle first push is not visible yet.
    assign pop       = ar_hs & ~is_status & ~empty;

    assign s_axis_tready = ~full;
    assign s_axi_arready = (state_q == ST_IDLE);
    assign s_axi_rvalid  = (state_q == ST_RESP);
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;

    assign s_axi_awready = 1'b0;
    assign s_axi_wready  = 1'b0;
    assign s_axi_bvalid  = 1'b0;
    assign s_axi_bresp   = 2'b00;

    logic unused_inputs;
    assign unused_inputs = ^{s_axi_araddr[AXI_ADDR_WIDTH-1:3], s_axi_araddr[1:0],
                             s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wvalid,
                             s_axi_bready};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (s_axi_arvalid) state_d = ST_RESP;
            ST_RESP: if (s_axi_rready)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        if (ar_hs) begin
            rresp_d = RESP_OKAY;
            if (is_status) begin
                rdata_d = {{(AXI_DATA_WIDTH-CW){1'b0}}, count_q};
            end else if (!empty) begin
                rdata_d = mem_q[rd_ptr_q];
            end else begin
                rdata_d = '0;
`ifdef AXI_AXIS_READER_EMPTY_ERR_EN
                rresp_d = RESP_SLVERR;
`else
                rresp_d = RESP_OKAY;
`endif
            end
        end
    end

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge aclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_axis_tdata;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= ST_IDLE;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
        end
    end

`ifndef SYNTHESIS
    logic unused_slverr;
    assign unused_slverr = ^RESP_SLVERR;

    a_rdata_stable: assert property (@(posedge aclk) disable iff (!aresetn)
        (s_axi_rvalid && !s_axi_rready) |=> ($stable(s_axi_rdata) && $stable(s_axi_rresp)));
    a_count_bound: assert property (@(posedge aclk) disable iff (!aresetn)
        count_q <= CNT_FULL);
`endif

endmodule
